// File: rtl/robot_nav_fsm.sv
// robot_nav_fsm
//   Navigation sequencer for the pipe robot. Chooses a turn from the wall
//   sensors, resolves heading from the lagging compass, steps LOCATION on a
//   2^COORD_W x 2^COORD_W grid and runs a timed maintenance action after a
//   successful move.
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous reset, active-high
//   ONOFF       01 power on, 10 power off, 00/11 no request
//   LCN_0       start location {x,y}, loaded on OFF->IDLE
//   MTN_SENSOR  {freeze, hot, plug, ok}, sampled when leaving MOVE
//   CMPS        one-hot compass {N,E,S,W}, sampled when leaving COMPASS
//   WLL         walls {left, front, right}, 1 = wall present
//   TURN        10 left, 01 right, 00 none
//   DRIVING     high in MOVE when the step stays on the grid
//   LOCATION    current {x,y}
//   ACTION      100 freeze, 010 hot, 001 plug, 000 none
//   STEP_CNT    completed moves since power-on, wraps
//   BUSY        high in every state except OFF and IDLE
//   CMPS_ERR    sticky invalid-compass flag, cleared on power-on
//
// state    | meaning
// ---------+-----------------------------------------------------
// OFF      | powered down, waiting for ONOFF=01
// IDLE     | reading walls to pick the next manoeuvre
// TURN_L   | single left turn
// TURN_R   | single right turn
// UTURN1   | first right turn of a dead-end U-turn
// UTURN2   | second right turn of a dead-end U-turn
// COMPASS  | loading heading from compass, corrected for lag
// MOVE     | one grid step (DRIVING only if it stays on the grid)
// MAINT    | holding ACTION for the configured number of cycles

module robot_nav_fsm #(
  parameter int COORD_W = 4,
  parameter int FZN_CYC = 5,
  parameter int PLG_CYC = 4,
  parameter int HOT_CYC = 3,
  parameter int STEP_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             ONOFF,
  input  logic [2*COORD_W-1:0]   LCN_0,
  input  logic [3:0]             MTN_SENSOR,
  input  logic [3:0]             CMPS,
  input  logic [2:0]             WLL,
  output logic [1:0]             TURN,
  output logic                   DRIVING,
  output logic [2*COORD_W-1:0]   LOCATION,
  output logic [2:0]             ACTION,
  output logic [STEP_W-1:0]      STEP_CNT,
  output logic                   BUSY,
  output logic                   CMPS_ERR
);

  localparam int MAX_CYC = (FZN_CYC > PLG_CYC) ? ((FZN_CYC > HOT_CYC) ? FZN_CYC : HOT_CYC)
                                               : ((PLG_CYC > HOT_CYC) ? PLG_CYC : HOT_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [COORD_W-1:0] EDGE_HI = {COORD_W{1'b1}};
  localparam logic [2:0] ACT_FZN = 3'b100;
  localparam logic [2:0] ACT_HOT = 3'b010;
  localparam logic [2:0] ACT_PLG = 3'b001;

  typedef enum logic [3:0] {
    S_OFF, S_IDLE, S_TURN_L, S_TURN_R, S_UTURN1, S_UTURN2, S_COMPASS, S_MOVE, S_MAINT
  } state_t;

  typedef enum logic [1:0] {M_STRAIGHT, M_LEFT, M_RIGHT, M_UTURN} mode_t;

  state_t               state_q, state_n;
  mode_t                mode_q, mode_n;
  logic [2*COORD_W-1:0] loc_q, loc_n;
  logic [STEP_W-1:0]    step_q, step_n;
  logic [3:0]           facing_q, facing_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [2:0]           kind_q, kind_n;
  logic                 err_q, err_n;
  logic                 cmps_onehot;
  logic [3:0]           cmps_rot;
  logic                 mtn_ok_unused;

  // The ok bit adds nothing beyond "no maintenance hit".
  assign mtn_ok_unused = MTN_SENSOR[0];

  function automatic logic step_legal(input logic [3:0] f, input logic [2*COORD_W-1:0] loc);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    x = loc[2*COORD_W-1:COORD_W];
    y = loc[COORD_W-1:0];
    case (f)
      4'b1000: return (y != EDGE_HI);
      4'b0100: return (x != EDGE_HI);
      4'b0010: return (y != '0);
      4'b0001: return (x != '0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2*COORD_W-1:0] step_loc(input logic [3:0] f,
                                                    input logic [2*COORD_W-1:0] loc);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    x = loc[2*COORD_W-1:COORD_W];
    y = loc[COORD_W-1:0];
    case (f)
      4'b1000: y = y + COORD_W'(1);
      4'b0100: x = x + COORD_W'(1);
      4'b0010: y = y - COORD_W'(1);
      4'b0001: x = x - COORD_W'(1);
      default: ;
    endcase
    return {x, y};
  endfunction

  assign cmps_onehot = (CMPS != 4'b0000) && ((CMPS & (CMPS - 4'd1)) == 4'b0000);

  // The compass reports the heading from before the last turn, so rotate it
  // by the turn just made: left = one step anticlockwise, etc.
  always_comb begin
    cmps_rot = CMPS;
    case (mode_q)
      M_STRAIGHT: cmps_rot = CMPS;
      M_LEFT:     cmps_rot = {CMPS[2:0], CMPS[3]};
      M_RIGHT:    cmps_rot = {CMPS[0], CMPS[3:1]};
      M_UTURN:    cmps_rot = {CMPS[1:0], CMPS[3:2]};
      default:    cmps_rot = CMPS;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    loc_n    = loc_q;
    step_n   = step_q;
    facing_n = facing_q;
    cnt_n    = cnt_q;
    kind_n   = kind_q;
    err_n    = err_q;
    if (state_q != S_OFF && ONOFF == 2'b10) begin
      state_n = S_OFF;
    end else begin
      case (state_q)
        S_OFF: if (ONOFF == 2'b01) begin
          state_n = S_IDLE;
          loc_n   = LCN_0;
          step_n  = '0;
          err_n   = 1'b0;
        end
        S_IDLE: begin
          if (!WLL[1]) begin
            state_n = S_COMPASS;
            mode_n  = M_STRAIGHT;
          end else if (!WLL[2]) state_n = S_TURN_L;
          else if (!WLL[0])     state_n = S_TURN_R;
          else                  state_n = S_UTURN1;
        end
        S_TURN_L: begin
          state_n = S_COMPASS;
          mode_n  = M_LEFT;
        end
        S_TURN_R: begin
          state_n = S_COMPASS;
          mode_n  = M_RIGHT;
        end
        S_UTURN1: state_n = S_UTURN2;
        S_UTURN2: begin
          state_n = S_COMPASS;
          mode_n  = M_UTURN;
        end
        S_COMPASS: begin
          if (cmps_onehot) begin
            facing_n = cmps_rot;
            state_n  = S_MOVE;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_MOVE: begin
          state_n = S_IDLE;
          if (step_legal(facing_q, loc_q)) begin
            loc_n  = step_loc(facing_q, loc_q);
            step_n = step_q + STEP_W'(1);
            if (MTN_SENSOR[3]) begin
              state_n = S_MAINT;
              kind_n  = ACT_FZN;
              cnt_n   = CNT_W'(FZN_CYC - 1);
            end else if (MTN_SENSOR[1]) begin
              state_n = S_MAINT;
              kind_n  = ACT_PLG;
              cnt_n   = CNT_W'(PLG_CYC - 1);
            end else if (MTN_SENSOR[2]) begin
              state_n = S_MAINT;
              kind_n  = ACT_HOT;
              cnt_n   = CNT_W'(HOT_CYC - 1);
            end
          end
        end
        S_MAINT: begin
          if (cnt_q == '0) state_n = S_IDLE;
          else             cnt_n   = cnt_q - CNT_W'(1);
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  // Outputs are decoded from the state being entered so that they are
  // registered yet still line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_OFF;
      mode_q   <= M_STRAIGHT;
      loc_q    <= '0;
      step_q   <= '0;
      facing_q <= 4'b1000;
      cnt_q    <= '0;
      kind_q   <= 3'b000;
      err_q    <= 1'b0;
      TURN     <= 2'b00;
      DRIVING  <= 1'b0;
      ACTION   <= 3'b000;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_n;
      mode_q   <= mode_n;
      loc_q    <= loc_n;
      step_q   <= step_n;
      facing_q <= facing_n;
      cnt_q    <= cnt_n;
      kind_q   <= kind_n;
      err_q    <= err_n;
      case (state_n)
        S_TURN_L:                     TURN <= 2'b10;
        S_TURN_R, S_UTURN1, S_UTURN2: TURN <= 2'b01;
        default:                      TURN <= 2'b00;
      endcase
      DRIVING <= (state_n == S_MOVE) && step_legal(facing_n, loc_n);
      ACTION  <= (state_n == S_MAINT) ? kind_n : 3'b000;
      BUSY    <= (state_n != S_OFF) && (state_n != S_IDLE);
    end
  end

  assign LOCATION = loc_q;
  assign STEP_CNT = step_q;
  assign CMPS_ERR = err_q;

endmodule

// File: tb/tb_robot_nav_fsm.sv
module tb_robot_nav_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  ONOFF;
  logic [7:0]  LCN_0;
  logic [3:0]  MTN_SENSOR;
  logic [3:0]  CMPS;
  logic [2:0]  WLL;
  logic [1:0]  TURN;
  logic        DRIVING;
  logic [7:0]  LOCATION;
  logic [2:0]  ACTION;
  logic [15:0] STEP_CNT;
  logic        BUSY;
  logic        CMPS_ERR;

  robot_nav_fsm dut (
    .CLK(CLK), .RST(RST), .ONOFF(ONOFF), .LCN_0(LCN_0), .MTN_SENSOR(MTN_SENSOR),
    .CMPS(CMPS), .WLL(WLL), .TURN(TURN), .DRIVING(DRIVING), .LOCATION(LOCATION),
    .ACTION(ACTION), .STEP_CNT(STEP_CNT), .BUSY(BUSY), .CMPS_ERR(CMPS_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  turn;
    logic        drv;
    logic [7:0]  loc;
    logic [2:0]  act;
    logic [15:0] step;
    logic        busy;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0] onoff;
    logic [7:0] lcn;
    logic [3:0] mtn;
    logic [3:0] cmps;
    logic [2:0] wll;
    exp_t       e;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t rec(logic [1:0] turn, logic drv, logic [7:0] loc, logic [2:0] act,
                               logic [15:0] step, logic busy, logic err);
    exp_t r;
    r.turn = turn; r.drv = drv; r.loc = loc; r.act = act;
    r.step = step; r.busy = busy; r.err = err;
    return r;
  endfunction

  function automatic vec_t mk(logic [1:0] onoff, logic [7:0] lcn, logic [3:0] mtn, logic [3:0] cmps,
                              logic [2:0] wll, logic [1:0] turn, logic drv, logic [7:0] loc,
                              logic [2:0] act, logic [15:0] step, logic busy, logic err);
    vec_t v;
    v.onoff = onoff; v.lcn = lcn; v.mtn = mtn; v.cmps = cmps; v.wll = wll;
    v.e = rec(turn, drv, loc, act, step, busy, err);
    return v;
  endfunction

  function automatic logic [7:0] pack_loc(int x, int y);
    return {x[3:0], y[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".TURN"},     32'(TURN),     32'(e.turn));
    chk({tag, ".DRIVING"},  32'(DRIVING),  32'(e.drv));
    chk({tag, ".LOCATION"}, 32'(LOCATION), 32'(e.loc));
    chk({tag, ".ACTION"},   32'(ACTION),   32'(e.act));
    chk({tag, ".STEP_CNT"}, 32'(STEP_CNT), 32'(e.step));
    chk({tag, ".BUSY"},     32'(BUSY),     32'(e.busy));
    chk({tag, ".CMPS_ERR"}, 32'(CMPS_ERR), 32'(e.err));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // behavioural model state for the random phase
  vec_t vecs[$];
  exp_t tr[$];
  exp_t prev, e;
  int   mx, my, nx, ny, heading, off, ncyc, cut;
  int   dxs[4] = '{0, 1, 0, -1};
  int   dys[4] = '{1, 0, -1, 0};
  logic [15:0] mstep;
  logic        merr;
  logic [1:0]  tv;
  logic [2:0]  av, rw;
  logic [3:0]  rc, rm;
  logic [7:0]  rl;

  initial begin
    RST = 1'b1; ONOFF = 2'b00; LCN_0 = 8'h00; MTN_SENSOR = 4'h0; CMPS = 4'h0; WLL = 3'b111;
    tick; tick;
    check_outs("reset", rec(2'b00, 0, 8'h00, 3'b000, 16'd0, 0, 0));
    RST = 1'b0;

    // directed walk: {onoff, lcn, mtn, cmps, wll} -> outputs after the edge
    vecs.push_back(mk(2'b01, 8'h35, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'h35, 3'b000, 0, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b011, 2'b10, 0, 8'h35, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b1000, 3'b011, 2'b00, 0, 8'h35, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b1000, 3'b011, 2'b00, 1, 8'h35, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h1, 4'b1000, 3'b011, 2'b00, 0, 8'h25, 3'b000, 1, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b101, 2'b00, 0, 8'h25, 3'b000, 1, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0100, 3'b101, 2'b00, 1, 8'h25, 3'b000, 1, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'hA, 4'b0100, 3'b101, 2'b00, 0, 8'h35, 3'b100, 2, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(2'b00, 8'h00, 4'h4, 4'b0000, 3'b111, 2'b00, 0, 8'h35, 3'b100, 2, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h4, 4'b0000, 3'b111, 2'b00, 0, 8'h35, 3'b000, 2, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b01, 0, 8'h35, 3'b000, 2, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b01, 0, 8'h35, 3'b000, 2, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'h35, 3'b000, 2, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b1000, 3'b111, 2'b00, 1, 8'h35, 3'b000, 2, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b1000, 3'b111, 2'b00, 0, 8'h34, 3'b000, 3, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b101, 2'b00, 0, 8'h34, 3'b000, 3, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0110, 3'b101, 2'b00, 0, 8'h34, 3'b000, 3, 0, 1));
    vecs.push_back(mk(2'b10, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'h34, 3'b000, 3, 0, 1));
    vecs.push_back(mk(2'b01, 8'hF0, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'hF0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b101, 2'b00, 0, 8'hF0, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0100, 3'b101, 2'b00, 0, 8'hF0, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h8, 4'b0100, 3'b111, 2'b00, 0, 8'hF0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b101, 2'b00, 0, 8'hF0, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b1000, 3'b101, 2'b00, 1, 8'hF0, 3'b000, 0, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h2, 4'b1000, 3'b111, 2'b00, 0, 8'hF1, 3'b001, 1, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'hF1, 3'b001, 1, 1, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'hF1, 3'b001, 1, 1, 0));
    vecs.push_back(mk(2'b10, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'hF1, 3'b000, 1, 0, 0));
    vecs.push_back(mk(2'b00, 8'h00, 4'h0, 4'b0000, 3'b111, 2'b00, 0, 8'hF1, 3'b000, 1, 0, 0));

    foreach (vecs[i]) begin
      ONOFF = vecs[i].onoff; LCN_0 = vecs[i].lcn; MTN_SENSOR = vecs[i].mtn;
      CMPS = vecs[i].cmps; WLL = vecs[i].wll;
      tick;
      check_outs($sformatf("vec%0d", i), vecs[i].e);
    end

    // reset in the middle of a hot maintenance, after a right turn at (7,7)
    ONOFF = 2'b01; LCN_0 = 8'h77; WLL = 3'b110; CMPS = 4'b0001; MTN_SENSOR = 4'b0100;
    tick;
    ONOFF = 2'b00;
    tick; check_outs("rst_seq.turn_r", rec(2'b01, 0, 8'h77, 3'b000, 0, 1, 0));
    tick; tick; check_outs("rst_seq.move", rec(2'b00, 1, 8'h77, 3'b000, 0, 1, 0));
    tick; check_outs("rst_seq.hot1", rec(2'b00, 0, 8'h78, 3'b010, 1, 1, 0));
    tick; check_outs("rst_seq.hot2", rec(2'b00, 0, 8'h78, 3'b010, 1, 1, 0));
    RST = 1'b1;
    tick; check_outs("rst_seq.reset", rec(2'b00, 0, 8'h00, 3'b000, 0, 0, 0));
    RST = 1'b0;
    tick; check_outs("rst_seq.stay_off", rec(2'b00, 0, 8'h00, 3'b000, 0, 0, 0));

    // randomized episodes against a heading/grid model
    cut = 0;
    for (int ep = 0; ep < 250; ep++) begin
      if (ep == 0 || cut >= 0) begin
        rl = 8'($urandom);
        case ($urandom_range(0, 3))
          0: rl[7:4] = 4'h0;
          1: rl[7:4] = 4'hF;
          2: rl[3:0] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF;
          default: ;
        endcase
        ONOFF = 2'b01; LCN_0 = rl;
        tick;
        mx = int'(rl[7:4]); my = int'(rl[3:0]); mstep = 0; merr = 1'b0;
        check_outs($sformatf("ep%0d.on", ep), rec(2'b00, 0, rl, 3'b000, mstep, 0, merr));
        ONOFF = 2'b00;
      end

      rw = 3'($urandom);
      rc = ($urandom_range(0, 4) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      rm = 4'($urandom);

      tr.delete();
      nx = mx; ny = my;
      if (!rw[1])      begin off = 0; ncyc = 0; tv = 2'b00; end
      else if (!rw[2]) begin off = 3; ncyc = 1; tv = 2'b10; end
      else if (!rw[0]) begin off = 1; ncyc = 1; tv = 2'b01; end
      else             begin off = 2; ncyc = 2; tv = 2'b01; end
      for (int t = 0; t < ncyc; t++)
        tr.push_back(rec(tv, 0, pack_loc(mx, my), 3'b000, mstep, 1, merr));
      tr.push_back(rec(2'b00, 0, pack_loc(mx, my), 3'b000, mstep, 1, merr));
      if ($countones(rc) != 1) begin
        tr.push_back(rec(2'b00, 0, pack_loc(mx, my), 3'b000, mstep, 0, 1'b1));
      end else begin
        heading = 0;
        for (int b = 0; b < 4; b++) if (rc[3-b]) heading = b;
        heading = (heading + off) % 4;
        nx = mx + dxs[heading];
        ny = my + dys[heading];
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          tr.push_back(rec(2'b00, 0, pack_loc(mx, my), 3'b000, mstep, 1, merr));
          tr.push_back(rec(2'b00, 0, pack_loc(mx, my), 3'b000, mstep, 0, merr));
        end else begin
          tr.push_back(rec(2'b00, 1, pack_loc(mx, my), 3'b000, mstep, 1, merr));
          if (rm[3])      begin av = 3'b100; ncyc = 5; end
          else if (rm[1]) begin av = 3'b001; ncyc = 4; end
          else if (rm[2]) begin av = 3'b010; ncyc = 3; end
          else            begin av = 3'b000; ncyc = 0; end
          for (int t = 0; t < ncyc; t++)
            tr.push_back(rec(2'b00, 0, pack_loc(nx, ny), av, mstep + 16'd1, 1, merr));
          tr.push_back(rec(2'b00, 0, pack_loc(nx, ny), 3'b000, mstep + 16'd1, 0, merr));
        end
      end

      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(0, tr.size() - 1) : -1;
      prev = rec(2'b00, 0, pack_loc(mx, my), 3'b000, mstep, 0, merr);
      WLL = rw; CMPS = rc; MTN_SENSOR = rm;
      foreach (tr[k]) begin
        if (k == cut) begin
          ONOFF = 2'b10;
          e = rec(2'b00, 0, prev.loc, 3'b000, prev.step, 0, prev.err);
        end else begin
          case ($urandom_range(0, 2))
            0: ONOFF = 2'b00;
            1: ONOFF = 2'b01;
            default: ONOFF = 2'b11;
          endcase
          e = tr[k];
        end
        tick;
        check_outs($sformatf("ep%0d.c%0d", ep, k), e);
        prev = e;
        if (k == cut) break;
      end
      ONOFF = 2'b00;
      if (cut < 0) begin
        mx = int'(prev.loc[7:4]); my = int'(prev.loc[3:0]);
        mstep = prev.step; merr = prev.err;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
